// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, image geometry and control-bundle type
// for the display path and the filter blocks that share frame buffer 2.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int IMG_W    = 320;
    localparam int IMG_H    = 240;

    localparam int ADDR_W   = 17;
    localparam int CNT_W    = 10;
    localparam int RGB_W    = 12;

    // Per-pixel control flags; syncs are stored active-low as driven on the pins.
    typedef struct packed {
        logic de;
        logic hsync_n;
        logic vsync_n;
    } vga_ctrl_t;

    localparam vga_ctrl_t CTRL_IDLE = '{de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

endpackage

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical counters with raw sync, active and frame strobes.
// All decodes are taken straight from the counter registers (undelayed domain).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACT   = H_ACTIVE,
    parameter int H_FRONT = H_FP,
    parameter int H_SYN   = H_SYNC,
    parameter int H_BACK  = H_BP,
    parameter int V_ACT   = V_ACTIVE,
    parameter int V_FRONT = V_FP,
    parameter int V_SYN   = V_SYNC,
    parameter int V_BACK  = V_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-2:0] col_o,
    output vga_ctrl_t        ctrl_o,
    output logic             line_step_o,
    output logic             frame_start_o,
    output logic             frame_wrap_o,
    output logic             frame_done_o
);

    localparam int H_TOT = H_ACT + H_FRONT + H_SYN + H_BACK;
    localparam int V_TOT = V_ACT + V_FRONT + V_SYN + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACT + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACT + H_FRONT + H_SYN);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACT + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACT + V_FRONT + V_SYN);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             h_wrap, v_wrap;

    // Counter next-state: hcnt wraps each line, vcnt steps on hcnt wrap.
    always_comb begin
        h_wrap = (hcnt_q == H_LAST);
        v_wrap = (vcnt_q == V_LAST);
        hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Raw timing decodes; line_step fires at the end of each odd visible line.
    always_comb begin
        ctrl_o.de      = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
        ctrl_o.hsync_n = !((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END));
        ctrl_o.vsync_n = !((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END));
        col_o          = hcnt_q[CNT_W-1:1];
        line_step_o    = h_wrap && vcnt_q[0] && (vcnt_q < V_ACT_C);
        frame_start_o  = (hcnt_q == '0) && (vcnt_q == '0);
        frame_wrap_o   = h_wrap && v_wrap;
        frame_done_o   = (hcnt_q == '0) && (vcnt_q == V_ACT_C);
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Display reader for frame buffer 2: scans the 320x240 image with 2x2 pixel
// replication, aligns sync/de with the 3-cycle read pipeline and gates colour.
module vga_frame_reader
    import vga_timing_pkg::*;
#(
    parameter int H_ACT     = H_ACTIVE,
    parameter int H_FRONT   = H_FP,
    parameter int H_SYN     = H_SYNC,
    parameter int H_BACK    = H_BP,
    parameter int V_ACT     = V_ACTIVE,
    parameter int V_FRONT   = V_FP,
    parameter int V_SYN     = V_SYNC,
    parameter int V_BACK    = V_BP,
    parameter int IMG_WIDTH = IMG_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              display_en,
    output logic [ADDR_W-1:0] rdaddr_buf2,
    input  logic [RGB_W-1:0]  din_buf2,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_de,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_WIDTH);

    logic [CNT_W-2:0]  col;
    vga_ctrl_t         ctrl_raw;
    logic              line_step, frame_start, frame_wrap;

    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
    logic              frame_en_q, frame_en_d;
    vga_ctrl_t         ctrl_p0_q, ctrl_p0_d;
    vga_ctrl_t         ctrl_p1_q, ctrl_p1_d;
    vga_ctrl_t         ctrl_p2_q, ctrl_p2_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;

    vga_sync_gen #(
        .H_ACT   (H_ACT),
        .H_FRONT (H_FRONT),
        .H_SYN   (H_SYN),
        .H_BACK  (H_BACK),
        .V_ACT   (V_ACT),
        .V_FRONT (V_FRONT),
        .V_SYN   (V_SYN),
        .V_BACK  (V_BACK)
    ) u_sync (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .col_o         (col),
        .ctrl_o        (ctrl_raw),
        .line_step_o   (line_step),
        .frame_start_o (frame_start),
        .frame_wrap_o  (frame_wrap),
        .frame_done_o  (frame_done)
    );

    // Address walk (accumulated line base, no multiplier), enable latch,
    // control alignment pipe and colour gating against the delayed de.
    always_comb begin
        line_base_d = line_base_q;
        if (frame_wrap) begin
            line_base_d = '0;
        end else if (line_step) begin
            line_base_d = line_base_q + LINE_STEP;
        end

        rdaddr_d = rdaddr_q;
        if (ctrl_raw.de) begin
            rdaddr_d = line_base_q + ADDR_W'(col);
        end

        frame_en_d = frame_start ? display_en : frame_en_q;

        ctrl_p0_d = ctrl_raw;
        ctrl_p1_d = ctrl_p0_q;
        ctrl_p2_d = ctrl_p1_q;

        // ctrl_p1 belongs to the same pixel as the din arriving this cycle.
        rgb_d = (ctrl_p1_q.de && frame_en_q) ? din_buf2 : '0;
    end

    // State registers; everything returns to the blanked idle state on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_base_q <= '0;
            rdaddr_q    <= '0;
            frame_en_q  <= 1'b0;
            ctrl_p0_q   <= CTRL_IDLE;
            ctrl_p1_q   <= CTRL_IDLE;
            ctrl_p2_q   <= CTRL_IDLE;
            rgb_q       <= '0;
        end else begin
            line_base_q <= line_base_d;
            rdaddr_q    <= rdaddr_d;
            frame_en_q  <= frame_en_d;
            ctrl_p0_q   <= ctrl_p0_d;
            ctrl_p1_q   <= ctrl_p1_d;
            ctrl_p2_q   <= ctrl_p2_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rdaddr_buf2 = rdaddr_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hsync   = ctrl_p2_q.hsync_n;
    assign vga_vsync   = ctrl_p2_q.vsync_n;
    assign vga_de      = ctrl_p2_q.de;

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Display-side consumer of frame buffer 2. Generates 640x480 at 60 Hz VGA timing from the 25 MHz pixel clock, reads the 320x240 RGB444 image that the grey/filter stages leave in buffer 2, and outputs each stored pixel as a 2x2 block. It owns the buffer-2 read port while no filter is running. It also reports end-of-active-frame so control logic can start filters during vertical blanking.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width (frame total 525)
- IMG_W, 320, stored image width in pixels; IMG_H = 240
- clk_i  in  1  25 MHz pixel clock; the only clock
- rst_i  in  1  reset, synchronous, active-high
- display_en  in  1  output enable, sampled once per frame
- rdaddr_buf2  out  17  buffer-2 read address
- din_buf2  in  12  buffer-2 read data {R[11:8],G[7:4],B[3:0]}, valid exactly 1 cycle after rdaddr_buf2
- vga_r / vga_g / vga_b  out  4 each  colour outputs
- vga_hsync / vga_vsync  out  1  sync outputs, active-low
- vga_de  out  1  active-video flag
- frame_done  out  1  one-cycle pulse at end of active frame

## Operation
- Counters: hcnt runs 0..799 and wraps to 0. vcnt increments when hcnt wraps, runs 0..524, and wraps to 0.
- Active region: hcnt<640 && vcnt<480.
- Horizontal sync low for hcnt in 656..751. Vertical sync low for vcnt in 490..491.
- Address: rdaddr_buf2 = line_base + (hcnt>>1). No multiplier is used.
  - line_base is 0 at vcnt 0.
  - line_base += IMG_W at end of every odd active line (vcnt[0]=1, hcnt=799).
  - line_base resets to 0 when vcnt wraps.
  - Each stored line is therefore shown twice and each pixel for two clocks.
- Outside the active region, rdaddr_buf2 holds its last value.
- Maximum address is 76799. An address above that is a design error; the bench asserts against it.
- display_en is latched into frame_en_r at hcnt=0, vcnt=0. Changes mid-frame take effect only at the next frame start.
- When frame_en_r=0: syncs and vga_de run normally, colours are 0.
- Colours are forced to 0 whenever delayed vga_de=0.
- frame_done pulses for exactly one cycle when the counters reach hcnt=0, vcnt=480 (undelayed counter domain).

## Timing
- Pipeline: counters at cycle t → rdaddr_buf2 registered, visible t+1 → din_buf2 valid t+2 → colours registered, visible t+3.
- vga_hsync, vga_vsync and vga_de pass through a 3-stage delay so all outputs are aligned with a 3-cycle lag from the counters.
- The first active pixel (address 0) appears on the pins at cycle 3 after reset release with vga_de=1.
- Reset values:
  - hcnt=0, vcnt=0, line_base=0, rdaddr_buf2=0.
  - vga_r/g/b=0, vga_hsync=1, vga_vsync=1, vga_de=0, frame_done=0, frame_en_r=0.
  - All delay stages clear to the inactive state.
- Reset mid-frame: on the next edge all state returns to the reset values and timing restarts from hcnt=0, vcnt=0. There is no partial-line output.
- hcnt=799 and vcnt=524 coincident: both wrap in the same cycle and line_base clears.

## Structure
- Shared package vga_timing_pkg: the timing constants, IMG_W/IMG_H, and the 17-bit address width constant, shared with filter blocks.
- Sub-module vga_sync_gen: hcnt/vcnt counters, raw hsync/vsync/active flags, frame_start and frame_done strobes.
- vga_frame_reader keeps the address generation, the 3-stage alignment delay and colour gating.

## Test plan
- Reset, then release: by cycle 3 vga_de=1 and colours equal din for address 0; before that vga_hsync=1, vga_vsync=1 and colours=0.
- Address doubling: rdaddr_buf2 sequence on line 0 is 0,0,1,1,…,319,319; line 1 repeats it; line 2 starts at 320; the last line ends at 76799.
- Sync positions: vga_hsync low for exactly 96 cycles starting 659 cycles after the line start (656 + 3 lag); line period 800; vga_vsync low for 2 lines; frame period 420000 cycles.
- frame_done: exactly one pulse per 420000 cycles, at hcnt=0, vcnt=480; none after reset until the first frame completes.
- display_en dropped at mid-frame line 100: colours stay valid through the frame and become 0 from the next frame start while syncs/de continue; re-asserting it restores video one frame later.
- Reset asserted at hcnt=300, vcnt=200: outputs equal the reset values the next cycle, and a full frame follows with correct sync counts.
